// File: rtl/dmem_responder_if.sv
// CPU-side request/response bundle for dmem_responder.
interface dmem_responder_if;
   logic        req;
   logic        we;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        ack;
   logic        busy;
   logic        err;

   modport master (
      output req, we, addr, wdata,
      input  rdata, ack, busy, err
   );

   modport slave (
      input  req, we, addr, wdata,
      output rdata, ack, busy, err
   );
endinterface

// File: rtl/dmem_responder.sv
// Wait-stated 16-bit data memory responder: IDLE -> WAIT (WAIT_CYCLES+1 edges) -> RESP.
// Define DMEM_ALIGN_CHECK_EN to flag and suppress odd-byte-address accesses.
module dmem_responder #(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic             clk,
   input logic             rst,
   dmem_responder_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            we_q;
   logic [AW-1:0]   idx_q;
   logic [15:0]     wdata_q;
   logic [15:0]     rdata_q;
   logic            mis_q;
   logic            accept;
   logic            access;
   logic            wr_en;
   logic            rd_en;
   logic            unused_addr;

   logic [15:0] mem [DEPTH];

   assign accept = (state_q == StIdle) && bus.req;
   assign access = (state_q == StWait) && (cnt_q == 4'd0);
   assign wr_en  = access && we_q && !mis_q;
   assign rd_en  = access && !we_q && !mis_q;

   // Only the word-index bits are stored; the rest of addr is deliberately dropped.
   assign unused_addr = ^bus.addr;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (bus.req) begin
               state_d = StWait;
               cnt_d   = 4'(WAIT_CYCLES);
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 16'h0000;
         rdata_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q    <= bus.we;
            idx_q   <= bus.addr[AW:1];
            wdata_q <= bus.wdata;
         end
         if (rd_en) begin
            rdata_q <= mem[idx_q];
         end
      end
   end

   // No reset on the array: contents survive rst, and an aborted WAIT never reaches wr_en.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[idx_q] <= wdata_q;
      end
   end

`ifdef DMEM_ALIGN_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mis_q <= 1'b0;
      end else if (accept) begin
         mis_q <= bus.addr[0];
      end
   end

   assign bus.err = (state_q == StResp) && mis_q;
`else
   assign mis_q   = 1'b0;
   assign bus.err = 1'b0;
`endif

   assign bus.ack   = (state_q == StResp);
   assign bus.busy  = (state_q != StIdle);
   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on a WAIT_CYCLES=2 instance plus hand
// sequences for reset, wrap/zero-wait (second instance) and held-req behaviour.
module tb_dmem_responder;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dmem_responder_if b2 ();
   dmem_responder_if b0 ();

   logic        t_req   [2];
   logic        t_we    [2];
   logic [15:0] t_addr  [2];
   logic [15:0] t_wdata [2];

   assign b2.req   = t_req[0];
   assign b2.we    = t_we[0];
   assign b2.addr  = t_addr[0];
   assign b2.wdata = t_wdata[0];
   assign b0.req   = t_req[1];
   assign b0.we    = t_we[1];
   assign b0.addr  = t_addr[1];
   assign b0.wdata = t_wdata[1];

   dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
   dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs [11];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // One access from idle; inputs are scrambled right after acceptance.
   task automatic op(input int d, input string name, input logic we, input logic [15:0] addr,
                     input logic [15:0] wdata, input logic [15:0] exp_rd, input logic exp_err,
                     input int exp_lat);
      int          lat;
      logic [15:0] rd;
      logic        er;
      lat = 99;
      rd  = 'x;
      er  = 'x;
      t_req[d] = 1'b1; t_we[d] = we; t_addr[d] = addr; t_wdata[d] = wdata;
      @(posedge clk); #1;
      t_req[d] = 1'b0; t_we[d] = ~we; t_addr[d] = ~addr; t_wdata[d] = ~wdata;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if ((d == 0) ? b2.ack : b0.ack) begin
            lat = c;
            rd  = (d == 0) ? b2.rdata : b0.rdata;
            er  = (d == 0) ? b2.err : b0.err;
            break;
         end
      end
      chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({name, "_rdata"}, {16'h0, rd}, {16'h0, exp_rd});
      chk({name, "_err"}, {31'h0, er}, {31'h0, exp_err});
      @(posedge clk); #1;
      chk({name, "_idle"}, (d == 0) ? {30'h0, b2.ack, b2.busy} : {30'h0, b0.ack, b0.busy}, 32'h0);
   endtask

   int          nack;
   int          ack_cyc [2];
   logic [15:0] ack_rd  [2];

   initial begin
      for (int i = 0; i < 2; i++) begin
         t_req[i] = 1'b0; t_we[i] = 1'b0; t_addr[i] = 16'h0; t_wdata[i] = 16'h0;
      end

      // Asynchronous reset, observed before any clock edge
      #2 rst = 1'b1;
      #1;
      chk("rst_ack", {31'h0, b2.ack}, 32'h0);
      chk("rst_busy", {31'h0, b2.busy}, 32'h0);
      chk("rst_err", {31'h0, b2.err}, 32'h0);
      chk("rst_rdata", {16'h0, b2.rdata}, 32'h0);
      #4 rst = 1'b0;
      @(posedge clk); #1;

      vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
      vecs[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
      vecs[2] = '{1'b1, 16'h0004, 16'h5555, 16'hBEEF, 1'b0};
      vecs[3] = '{1'b1, 16'h0020, 16'h1111, 16'hBEEF, 1'b0};
      vecs[4] = '{1'b0, 16'h0004, 16'h0000, 16'h5555, 1'b0};
      vecs[5] = '{1'b0, 16'h0220, 16'h0000, 16'h1111, 1'b0};
      vecs[6] = '{1'b1, 16'h01FE, 16'hCAFE, 16'h1111, 1'b0};
      vecs[7] = '{1'b0, 16'hFFFE, 16'h0000, 16'hCAFE, 1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
      vecs[8]  = '{1'b1, 16'h0011, 16'hFFFF, 16'hCAFE, 1'b1};
      vecs[9]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
      vecs[10] = '{1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b1};
`else
      vecs[8]  = '{1'b1, 16'h0011, 16'hFFFF, 16'hCAFE, 1'b0};
      vecs[9]  = '{1'b0, 16'h0010, 16'h0000, 16'hFFFF, 1'b0};
      vecs[10] = '{1'b0, 16'h0005, 16'h0000, 16'h5555, 1'b0};
`endif
      for (int i = 0; i < 11; i++) begin
         op(0, $sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
            vecs[i].exp_rd, vecs[i].exp_err, 3);
      end

      // Reset during WAIT aborts the write of 0xAAAA over 0x5555
      t_req[0] = 1'b1; t_we[0] = 1'b1; t_addr[0] = 16'h0004; t_wdata[0] = 16'hAAAA;
      @(posedge clk); #1;
      t_req[0] = 1'b0;
      chk("wait_busy", {31'h0, b2.busy}, 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", {31'h0, b2.busy}, 32'h0);
      chk("abort_rdata", {16'h0, b2.rdata}, 32'h0);
      @(posedge clk); #3 rst = 1'b0;
      @(posedge clk); #1;
      op(0, "abort_rd", 1'b0, 16'h0004, 16'h0000, 16'h5555, 1'b0, 3);

      // Reset during RESP drops ack without waiting for an edge
      t_req[0] = 1'b1; t_we[0] = 1'b0; t_addr[0] = 16'h0010;
      @(posedge clk); #1;
      t_req[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("resp_ack", {31'h0, b2.ack}, 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("resp_drop", {31'h0, b2.ack}, 32'h0);
      #2 rst = 1'b0;
      @(posedge clk); #1;

      // Zero wait states and address wrap on the second instance
      op(1, "wrap_wr", 1'b1, 16'h0202, 16'h1234, 16'h0000, 1'b0, 1);
      op(1, "wrap_rd", 1'b0, 16'h0002, 16'h0000, 16'h1234, 1'b0, 1);

      // req held high with a churning address bus
      op(0, "pre_wr0", 1'b1, 16'h0030, 16'hA1A1, 16'h0000, 1'b0, 3);
      op(0, "pre_wr1", 1'b1, 16'h0032, 16'hB2B2, 16'h0000, 1'b0, 3);
      nack = 0;
      t_req[0] = 1'b1; t_we[0] = 1'b0; t_addr[0] = 16'h0030; t_wdata[0] = 16'h0;
      @(posedge clk); #1;
      for (int c = 1; c <= 12; c++) begin
         t_addr[0]  = (c == 5) ? 16'h0032 : 16'h0100 + 16'(c * 2);
         t_we[0]    = (c == 2);
         t_wdata[0] = 16'h7000 + 16'(c);
         if (c == 9) t_req[0] = 1'b0;
         @(posedge clk); #1;
         if (b2.ack) begin
            if (nack < 2) begin
               ack_cyc[nack] = c;
               ack_rd[nack]  = b2.rdata;
            end
            nack++;
         end
         if (c == 4) chk("gap_idle", {31'h0, b2.busy}, 32'h0);
         if (c == 5) chk("reaccept", {31'h0, b2.busy}, 32'h1);
      end
      chk("held_nack", 32'(nack), 32'd2);
      if (nack >= 2) begin
         chk("held_cyc0", 32'(ack_cyc[0]), 32'd3);
         chk("held_cyc1", 32'(ack_cyc[1]), 32'd8);
         chk("held_rd0", {16'h0, ack_rd[0]}, 32'h0000A1A1);
         chk("held_rd1", {16'h0, ack_rd[1]}, 32'h0000B2B2);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
